vending_machine: RTL and testbench
==================================

# vending_machine

Three-product coin-operated vending controller. Accepts 5- and 10-unit coins, tracks credit as a state machine and dispenses product A, B or C once credit covers the selected price. Issues a change-return pulse on overpayment or cancel. Sits between the coin acceptor/keypad front-end and the dispenser/refund actuators; all outputs are single-cycle registered strobes.

## Interface
- No parameters. Prices and coin values are fixed constants in the shared package.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: one clock; reset is synchronous and active-low.
- `cancel` input 1: abort transaction and refund credit; level, sampled each edge.
- `coin` input 2: 00 no coin, 01 = 5 units, 10 = 10 units, 11 invalid (ignored). Each non-zero cycle counts as one coin.
- `sel` input 2: 00 product A (price 5), 01 B (price 10), 10 C (price 15), 11 no selection.
- `pa` / `pb` / `pc` output 1 each: dispense strobes for A/B/C, one cycle.
- `change` output 1: refund/change strobe, one cycle.

## Operation
- Credit FSM states: S0, S5, S10, S15, S20 (credit in units). Reset state is S0.
- Each rising edge with `reset`=1, compute `nc` = credit + value(coin). `value`: 01→5, 10→10, else 0.
- Priority 1, cancel: if `cancel`=1, go to S0. `change`=1 if `nc`>0, else 0. No dispense; the coin that arrives on the same edge is refunded too.
- Priority 2, overflow: if `nc`>20, ignore the coin this edge; `nc` = credit.
- Priority 3, vend: if `sel`≠11 and `nc` ≥ price(sel), pulse the matching `pa`/`pb`/`pc`. `change`=1 iff `nc` > price. Go to S0. Change amount is not encoded; the single pulse means "return excess".
- Otherwise: state ← `nc`; all outputs 0.
- Only one of `pa`/`pb`/`pc` is ever high in a given cycle.
- `sel` is level-sensitive. A held selection vends as soon as credit suffices, including on the same edge that the coin arrives.

## Timing
- All outputs are registered. Reset value of `pa`, `pb`, `pc` and `change` is 0, and the state is S0.
- Latency: inputs are sampled at edge N; strobes are high from edge N to edge N+1, exactly one cycle.
- Reset has priority over everything. Reset mid-transaction discards credit with no change pulse.
- Back-to-back transactions are allowed. The cycle after a vend starts at S0, and a coin on that edge begins new credit.
- Simultaneous coin and vend-eligible selection: the coin is counted before the price compare.

## Structure
- Package `vm_pkg` holds:
  - coin encodings and coin values (5, 10);
  - sel encodings including SEL_NONE = 11;
  - prices (A = 5, B = 10, C = 15);
  - MAX_CREDIT = 20;
  - the state enum S0..S20.
- Single module. No sub-module is needed. The price lookup is a combinational function in the package.

## Test plan
- Reset low for 2 cycles, then high with coin=00 and sel=11 → all outputs 0, state S0.
- sel=00, coin=01 for one cycle → `pa`=1 for one cycle, `change`=0, back to S0.
- sel=11, coin=10 for one cycle, then sel=01 → `pb`=1 one cycle, `change`=0. Repeat with coin=01 twice and sel=01 → same result.
- sel=10, coin=10 twice → `pc`=1 and `change`=1 on the second coin's cycle (credit 20 > 15).
- sel=11, coin=10 twice, then coin=01 → the third coin is ignored (would reach 25), state stays S20. Then cancel=1 → `change`=1, no dispense, S0.
- With credit at S10, assert `reset`=0 → outputs 0, S0, no change pulse. A coin=11 cycle never alters state.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared constants, encodings and helpers for the vending machine controller.
// Coin/selection encodings, coin values, product prices, credit ceiling,
// the credit state enum and small combinational lookups.
package vm_pkg;

  localparam int unsigned COIN_W   = 2;
  localparam int unsigned SEL_W    = 2;
  // Wide enough for the largest intermediate sum (20 + 10 = 30).
  localparam int unsigned CREDIT_W = 5;

  localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
  localparam logic [COIN_W-1:0] COIN_5    = 2'b01;
  localparam logic [COIN_W-1:0] COIN_10   = 2'b10;
  localparam logic [COIN_W-1:0] COIN_BAD  = 2'b11;

  localparam logic [CREDIT_W-1:0] VAL_5  = 5'd5;
  localparam logic [CREDIT_W-1:0] VAL_10 = 5'd10;

  localparam logic [SEL_W-1:0] SEL_A    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_B    = 2'b01;
  localparam logic [SEL_W-1:0] SEL_C    = 2'b10;
  localparam logic [SEL_W-1:0] SEL_NONE = 2'b11;

  localparam logic [CREDIT_W-1:0] PRICE_A    = 5'd5;
  localparam logic [CREDIT_W-1:0] PRICE_B    = 5'd10;
  localparam logic [CREDIT_W-1:0] PRICE_C    = 5'd15;
  localparam logic [CREDIT_W-1:0] MAX_CREDIT = 5'd20;

  typedef enum logic [2:0] {
    S0  = 3'd0,
    S5  = 3'd1,
    S10 = 3'd2,
    S15 = 3'd3,
    S20 = 3'd4
  } state_e;

  // Value of a coin code; invalid and idle codes add nothing.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [COIN_W-1:0] coin);
    case (coin)
      COIN_5:  coin_value = VAL_5;
      COIN_10: coin_value = VAL_10;
      default: coin_value = '0;
    endcase
  endfunction

  // Price of the selected product; SEL_NONE returns 0 and must be gated by the caller.
  function automatic logic [CREDIT_W-1:0] price(input logic [SEL_W-1:0] sel);
    case (sel)
      SEL_A:   price = PRICE_A;
      SEL_B:   price = PRICE_B;
      SEL_C:   price = PRICE_C;
      default: price = '0;
    endcase
  endfunction

  // Credit held in a given state.
  function automatic logic [CREDIT_W-1:0] state_credit(input state_e st);
    case (st)
      S5:      state_credit = 5'd5;
      S10:     state_credit = 5'd10;
      S15:     state_credit = 5'd15;
      S20:     state_credit = 5'd20;
      default: state_credit = 5'd0;
    endcase
  endfunction

  // State holding a given credit; callers only pass multiples of 5 up to MAX_CREDIT.
  function automatic state_e credit_state(input logic [CREDIT_W-1:0] credit);
    case (credit)
      5'd5:    credit_state = S5;
      5'd10:   credit_state = S10;
      5'd15:   credit_state = S15;
      5'd20:   credit_state = S20;
      default: credit_state = S0;
    endcase
  endfunction

endpackage

// File: rtl/vending_machine.sv
// Three-product coin-operated vending controller.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-low reset
//   cancel - abort and refund current credit (level)
//   coin   - 01 = 5 units, 10 = 10 units, 00/11 = nothing
//   sel    - 00 A (5), 01 B (10), 10 C (15), 11 none (level)
//   pa/pb/pc - one-cycle dispense strobes
//   change   - one-cycle refund/change strobe
module vending_machine
  import vm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cancel,
  input  logic [COIN_W-1:0] coin,
  input  logic [SEL_W-1:0]  sel,
  output logic              pa,
  output logic              pb,
  output logic              pc,
  output logic              change
);

  state_e state_q, state_d;
  logic   pa_q, pa_d;
  logic   pb_q, pb_d;
  logic   pc_q, pc_d;
  logic   change_q, change_d;

  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] nc;
  logic [CREDIT_W-1:0] nc_eff;
  logic [CREDIT_W-1:0] prc;

  // Next credit and strobes: cancel, then overflow rejection, then vend.
  always_comb begin
    state_d  = state_q;
    pa_d     = 1'b0;
    pb_d     = 1'b0;
    pc_d     = 1'b0;
    change_d = 1'b0;
    credit   = state_credit(state_q);
    nc       = credit + coin_value(coin);
    nc_eff   = nc;
    prc      = price(sel);

    if (cancel) begin
      // A coin arriving with cancel is refunded along with the held credit.
      state_d  = S0;
      change_d = (nc != '0);
    end else begin
      // A coin that would push credit past the ceiling is not accepted.
      if (nc > MAX_CREDIT) begin
        nc_eff = credit;
      end
      if ((sel != SEL_NONE) && (nc_eff >= prc)) begin
        case (sel)
          SEL_A:   pa_d = 1'b1;
          SEL_B:   pb_d = 1'b1;
          SEL_C:   pc_d = 1'b1;
          default: ;
        endcase
        change_d = (nc_eff > prc);
        state_d  = S0;
      end else begin
        state_d = credit_state(nc_eff);
      end
    end
  end

  // State and registered strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S0;
      pa_q     <= 1'b0;
      pb_q     <= 1'b0;
      pc_q     <= 1'b0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
      pc_q     <= pc_d;
      change_q <= change_d;
    end
  end

  assign pa     = pa_q;
  assign pb     = pb_q;
  assign pc     = pc_q;
  assign change = change_q;

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine: directed scenarios followed by
// randomized stimulus, compared against an integer-credit reference model.
module tb_vending_machine;

  logic       clk;
  logic       reset;
  logic       cancel;
  logic [1:0] coin;
  logic [1:0] sel;
  logic       pa, pb, pc, change;

  int n_checks;
  int n_pass;
  int model_credit;

  vending_machine dut (
    .clk    (clk),
    .reset  (reset),
    .cancel (cancel),
    .coin   (coin),
    .sel    (sel),
    .pa     (pa),
    .pb     (pb),
    .pc     (pc),
    .change (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got {pa,pb,pc,chg}=%b expected=%b", tag, got, exp);
  endtask

  // Applies one cycle of inputs, advances the model, and checks outputs after the edge.
  task automatic step(input string tag, input logic rst_n, input logic cnl,
                      input logic [1:0] cn, input logic [1:0] sl);
    int v, total, p;
    logic [3:0] exp;
    @(negedge clk);
    reset  = rst_n;
    cancel = cnl;
    coin   = cn;
    sel    = sl;
    exp    = 4'b0000;
    if (!rst_n) begin
      model_credit = 0;
    end else begin
      v     = (cn == 2'b01) ? 5 : (cn == 2'b10) ? 10 : 0;
      total = model_credit + v;
      if (cnl) begin
        exp[0]       = (total > 0);
        model_credit = 0;
      end else begin
        if (total > 20) total = model_credit;
        p = (sl == 2'b00) ? 5 : (sl == 2'b01) ? 10 : (sl == 2'b10) ? 15 : -1;
        if (p > 0 && total >= p) begin
          exp[3 - int'(sl)] = 1'b1;
          exp[0]            = (total > p);
          model_credit      = 0;
        end else begin
          model_credit = total;
        end
      end
    end
    @(posedge clk);
    #1;
    check_eq(tag, {pa, pb, pc, change}, exp);
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    model_credit = 0;
    reset  = 1'b0;
    cancel = 1'b0;
    coin   = 2'b00;
    sel    = 2'b11;

    step("rst0", 1'b0, 1'b0, 2'b00, 2'b11);
    step("rst1", 1'b0, 1'b0, 2'b00, 2'b11);
    step("idle", 1'b1, 1'b0, 2'b00, 2'b11);

    step("vend_a", 1'b1, 1'b0, 2'b01, 2'b00);
    step("after_a", 1'b1, 1'b0, 2'b00, 2'b11);

    step("b_coin10", 1'b1, 1'b0, 2'b10, 2'b11);
    step("b_sel", 1'b1, 1'b0, 2'b00, 2'b01);
    step("b2_coin5a", 1'b1, 1'b0, 2'b01, 2'b01);
    step("b2_coin5b", 1'b1, 1'b0, 2'b01, 2'b01);
    step("b2_idle", 1'b1, 1'b0, 2'b00, 2'b11);

    step("c_coin1", 1'b1, 1'b0, 2'b10, 2'b10);
    step("c_coin2_chg", 1'b1, 1'b0, 2'b10, 2'b10);

    step("ovf_c1", 1'b1, 1'b0, 2'b10, 2'b11);
    step("ovf_c2", 1'b1, 1'b0, 2'b10, 2'b11);
    step("ovf_reject", 1'b1, 1'b0, 2'b01, 2'b11);
    step("ovf_hold", 1'b1, 1'b0, 2'b00, 2'b11);
    step("cancel_s20", 1'b1, 1'b1, 2'b00, 2'b11);
    step("cancel_empty", 1'b1, 1'b1, 2'b00, 2'b11);
    step("cancel_coin", 1'b1, 1'b1, 2'b01, 2'b11);

    step("mid_c10", 1'b1, 1'b0, 2'b10, 2'b11);
    step("mid_reset", 1'b0, 1'b0, 2'b00, 2'b11);
    step("post_reset_b", 1'b1, 1'b0, 2'b00, 2'b01);
    step("bad_coin", 1'b1, 1'b0, 2'b11, 2'b11);
    step("bad_coin_a", 1'b1, 1'b0, 2'b00, 2'b00);
    step("s20_vend_a", 1'b1, 1'b0, 2'b10, 2'b11);
    step("s20_vend_a2", 1'b1, 1'b0, 2'b10, 2'b11);
    step("s20_vend_a3", 1'b1, 1'b0, 2'b10, 2'b00);

    for (int i = 0; i < 600; i++) begin
      logic       r, c;
      logic [1:0] cn, sl;
      r  = ($urandom_range(0, 49) != 0);
      c  = ($urandom_range(0, 11) == 0);
      cn = 2'($urandom_range(0, 3));
      sl = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      step("rand", r, c, cn, sl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
